// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG-to-AHB debug access port.
// Holds the TAP and AHB master state encodings, IR opcodes and HTRANS codes.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    UPD_IR   = 4'h1,
    EX2_IR   = 4'h2,
    PAUSE_IR = 4'h3,
    EX1_IR   = 4'h4,
    SHIFT_IR = 4'h5,
    CAP_IR   = 4'h6,
    SEL_IR   = 4'h7,
    UPD_DR   = 4'h8,
    EX2_DR   = 4'h9,
    PAUSE_DR = 4'hA,
    EX1_DR   = 4'hB,
    SHIFT_DR = 4'hC,
    CAP_DR   = 4'hD,
    SEL_DR   = 4'hE,
    RTI      = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_ADDR = 2'd1,
    M_DATA = 2'd2
  } ahb_state_t;

  typedef enum logic [2:0] {
    CH_BYPASS,
    CH_IDCODE,
    CH_ADDR,
    CH_WDATA,
    CH_RDATA,
    CH_STATUS
  } chain_t;

  localparam logic [3:0] OP_BYPASS = 4'b0000;
  localparam logic [3:0] OP_IDCODE = 4'b1000;
  localparam logic [3:0] OP_ADDR   = 4'b0100;
  localparam logic [3:0] OP_WDATA  = 4'b1100;
  localparam logic [3:0] OP_RDATA  = 4'b0010;
  localparam logic [3:0] OP_STATUS = 4'b1010;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller clocked by TCK with synchronous TRST.
// Exposes the raw state plus one-hot capture/shift/update decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state,
  output logic       cap_dr,
  output logic       shift_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       shift_ir,
  output logic       upd_ir
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge TCK) begin
    if (TRST) state_q <= TLR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = TMS ? TLR      : RTI;
      RTI:      state_d = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = TMS ? EX1_DR   : SHIFT_DR;
      SHIFT_DR: state_d = TMS ? EX1_DR   : SHIFT_DR;
      EX1_DR:   state_d = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = TMS ? EX1_IR   : SHIFT_IR;
      SHIFT_IR: state_d = TMS ? EX1_IR   : SHIFT_IR;
      EX1_IR:   state_d = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  assign state    = state_q;
  assign cap_dr   = (state_q == CAP_DR);
  assign shift_dr = (state_q == SHIFT_DR);
  assign upd_dr   = (state_q == UPD_DR);
  assign cap_ir   = (state_q == CAP_IR);
  assign shift_ir = (state_q == SHIFT_IR);
  assign upd_ir   = (state_q == UPD_IR);

endmodule

// File: rtl/jtag_ahb_dap.sv
// JTAG debug access port: IR, DR chains, TDO mux and an AHB-Lite single-transfer master.
// Optional build macro JTAG_AUTOINC_EN: addr_reg steps by DATA_W/8 after each good transfer.
module jtag_ahb_dap
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] IDCODE_VAL = 32'hF0F0F0F0
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic [ADDR_W-1:0] HADDR,
  output tap_state_t        tap_state,
  output ahb_state_t        ahb_state
);

  localparam int DR_W = (ADDR_W > DATA_W) ? ((ADDR_W > 32) ? ADDR_W : 32)
                                          : ((DATA_W > 32) ? DATA_W : 32);

  tap_state_t state;
  logic cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir;

  jtag_tap_fsm u_tap (
    .TCK      (TCK),
    .TRST     (TRST),
    .TMS      (TMS),
    .state    (state),
    .cap_dr   (cap_dr),
    .shift_dr (shift_dr),
    .upd_dr   (upd_dr),
    .cap_ir   (cap_ir),
    .shift_ir (shift_ir),
    .upd_ir   (upd_ir)
  );

  logic [IR_W-1:0]   ir_shift, ir_reg;
  logic [DR_W-1:0]   dr_shift, dr_shifted, cap_val, shift_val;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg, rdata_reg;
  logic              err, overrun, busy;
  chain_t            chain;
  int                chain_len;

  ahb_state_t        m_state, m_next;
  logic [1:0]        htrans_nxt;
  logic [ADDR_W-1:0] haddr_nxt;
  logic              hwrite_nxt;
  logic [DATA_W-1:0] hwdata_nxt, rdata_nxt;
  logic              set_err;

  // Unlisted opcodes (including any with nonzero upper IR bits) fall back to BYPASS.
  always_comb begin
    chain = CH_BYPASS;
    if      (ir_reg == IR_W'(OP_IDCODE)) chain = CH_IDCODE;
    else if (ir_reg == IR_W'(OP_ADDR))   chain = CH_ADDR;
    else if (ir_reg == IR_W'(OP_WDATA))  chain = CH_WDATA;
    else if (ir_reg == IR_W'(OP_RDATA))  chain = CH_RDATA;
    else if (ir_reg == IR_W'(OP_STATUS)) chain = CH_STATUS;
  end

  always_comb begin
    chain_len = 1;
    cap_val   = '0;
    case (chain)
      CH_IDCODE: begin chain_len = 32;     cap_val[31:0]       = IDCODE_VAL; end
      CH_ADDR:   begin chain_len = ADDR_W; cap_val[ADDR_W-1:0] = addr_reg;   end
      CH_WDATA:  begin chain_len = DATA_W; cap_val[DATA_W-1:0] = wdata_reg;  end
      CH_RDATA:  begin chain_len = DATA_W; cap_val[DATA_W-1:0] = rdata_reg;  end
      CH_STATUS: begin chain_len = 3;      cap_val[2:0] = {overrun, err, busy}; end
      default:   begin chain_len = 1;      cap_val      = '0;                end
    endcase
  end

  // TDI enters at the MSB of the active chain length, not of the shared register.
  assign dr_shifted = dr_shift >> 1;
  always_comb begin
    shift_val = '0;
    for (int i = 0; i < DR_W; i++) begin
      if (i == chain_len - 1)     shift_val[i] = TDI;
      else if (i < chain_len - 1) shift_val[i] = dr_shifted[i];
      else                        shift_val[i] = 1'b0;
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_shift <= '0;
      ir_reg   <= '0;
      dr_shift <= '0;
    end else begin
      if (cap_ir)        ir_shift <= IR_W'(1);
      else if (shift_ir) ir_shift <= {TDI, ir_shift[IR_W-1:1]};
      if (state == TLR)  ir_reg   <= '0;
      else if (upd_ir)   ir_reg   <= ir_shift;
      if (cap_dr)        dr_shift <= cap_val;
      else if (shift_dr) dr_shift <= shift_val;
    end
  end

  always_ff @(negedge TCK) begin
    if (TRST)          TDO <= 1'b0;
    else if (shift_ir) TDO <= ir_shift[0];
    else if (shift_dr) TDO <= dr_shift[0];
  end

  logic wr_req, rd_req, req, addr_wr, stat_clr;
  assign wr_req   = upd_dr && (chain == CH_WDATA);
  assign rd_req   = upd_dr && (chain == CH_RDATA);
  assign req      = wr_req || rd_req;
  assign addr_wr  = upd_dr && (chain == CH_ADDR);
  assign stat_clr = upd_dr && (chain == CH_STATUS);
  assign busy     = (m_state != M_IDLE);

  // AHB handshake: a phase (address or data) completes on the rising TCK where HREADY=1;
  // until then every master output holds. HTRANS=NONSEQ marks the address phase only.
  always_comb begin
    m_next     = m_state;
    htrans_nxt = HTRANS;
    haddr_nxt  = HADDR;
    hwrite_nxt = HWRITE;
    hwdata_nxt = HWDATA;
    rdata_nxt  = rdata_reg;
    set_err    = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (req) begin
          m_next     = M_ADDR;
          htrans_nxt = HTRANS_NONSEQ;
          haddr_nxt  = addr_reg;
          hwrite_nxt = wr_req;
        end
      end
      M_ADDR: begin
        if (HREADY) begin
          m_next     = M_DATA;
          htrans_nxt = HTRANS_IDLE;
          if (HWRITE) hwdata_nxt = wdata_reg;
        end
      end
      M_DATA: begin
        if (HREADY) begin
          m_next = M_IDLE;
          if (HRESP)        set_err   = 1'b1;
          else if (!HWRITE) rdata_nxt = HRDATA;
        end
      end
      default: m_next = M_IDLE;
    endcase
  end

`ifdef JTAG_AUTOINC_EN
  logic inc_addr;
  assign inc_addr = (m_state == M_DATA) && HREADY && !HRESP;
`endif

  always_ff @(posedge TCK) begin
    if (TRST) begin
      m_state   <= M_IDLE;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rdata_reg <= '0;
      wdata_reg <= '0;
      addr_reg  <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      m_state   <= m_next;
      HTRANS    <= htrans_nxt;
      HADDR     <= haddr_nxt;
      HWRITE    <= hwrite_nxt;
      HWDATA    <= hwdata_nxt;
      rdata_reg <= rdata_nxt;
      err       <= set_err | (err & ~stat_clr);
      overrun   <= (req & busy) | (overrun & ~stat_clr);
      if (wr_req) wdata_reg <= dr_shift[DATA_W-1:0];
      if (addr_wr) addr_reg <= dr_shift[ADDR_W-1:0];
`ifdef JTAG_AUTOINC_EN
      else if (inc_addr) addr_reg <= addr_reg + ADDR_W'(DATA_W / 8);
`endif
    end
  end

  assign tap_state = state;
  assign ahb_state = m_state;

endmodule

// File: doc/jtag_ahb_dap.md
Name: jtag_ahb_dap

Overview:
- Parametrised next-generation JTAG debug access port: 16-state TAP controller, variable-width IR/DR chain, and an AHB-Lite single-transfer master. Everything runs on one clock, TCK.
- Adds over the previous generation:
  - true reads via the RDATA chain;
  - readback of ADDR/WDATA;
  - a STATUS register with sticky bus-error and overrun flags;
  - a proper address/data-phase AHB handshake.
- Sits between the board JTAG header and the system AHB fabric as a debug master.

Parameters:
- IR_W, 4, instruction register width (min 4; opcodes zero-extended).
- ADDR_W, 32, HADDR width and ADDR chain length.
- DATA_W, 32, HWDATA/HRDATA width and WDATA/RDATA chain length (8, 16 or 32).
- IDCODE_VAL, 32'hF0F0F0F0, value captured by the IDCODE chain.

Ports:
- TCK  in  1  clock; all state changes on rising edge except TDO.
- TRST  in  1  reset. Synchronous active-high.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, updated on falling TCK.
- HREADY  in  1  AHB transfer-done / ready.
- HRESP  in  1  AHB error response (1 = ERROR).
- HRDATA  in  DATA_W  AHB read data.
- HWRITE  out  1  AHB direction (1 = write).
- HTRANS  out  2  AHB transfer type (00 IDLE, 10 NONSEQ only).
- HWDATA  out  DATA_W  AHB write data.
- HADDR  out  ADDR_W  AHB address.

Behaviour:
- Reset values (TRST=1 at rising TCK):
  - TAP goes to TEST_LOGIC_RESET; IR=0 (BYPASS); AHB FSM goes to M_IDLE.
  - TDO=0, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0.
  - addr_reg=0, wdata_reg=0, rdata_reg=0, all sticky flags=0.
- TAP:
  - Standard IEEE 1149.1 transitions on TMS.
  - State codes: TLR=0, RTI=F, SEL_DR=E, CAP_DR=D, SHIFT_DR=C, EX1_DR=B, PAUSE_DR=A, EX2_DR=9, UPD_DR=8, SEL_IR=7, CAP_IR=6, SHIFT_IR=5, EX1_IR=4, PAUSE_IR=3, EX2_IR=2, UPD_IR=1.
  - Five TMS=1 edges reach TLR from any state.
- IR:
  - CAP_IR loads ...01 (LSB=1, per 1149.1).
  - SHIFT_IR shifts TDI into the MSB, LSB-first out.
  - Active instruction latches on UPD_IR. TLR forces BYPASS.
- Opcodes:
  - BYPASS=0000, IDCODE=1000, ADDR=0100, WDATA=1100, RDATA=0010, STATUS=1010.
  - Any other value behaves as BYPASS.
- DR chains: all shift TDI into the MSB, LSB out. Capture and update actions by chain:
  - BYPASS: 1 bit; capture 0.
  - IDCODE: 32 bits; capture IDCODE_VAL; update ignored.
  - ADDR: capture addr_reg; UPD_DR writes addr_reg.
  - WDATA: capture wdata_reg; UPD_DR writes wdata_reg and requests a write.
  - RDATA: capture rdata_reg; UPD_DR requests a read at addr_reg.
  - STATUS: 3 bits, {overrun, err, busy}. Capture current values; UPD_DR clears err and overrun.
- TDO:
  - On falling TCK, TDO = LSB of the active chain in SHIFT_IR/SHIFT_DR.
  - In all other states TDO holds its value.
- AHB FSM:
  - M_IDLE: on request, the next edge goes to M_ADDR with HTRANS=10, HADDR=addr_reg, and HWRITE=1 for write / 0 for read.
  - M_ADDR: hold outputs until HREADY=1. Then go to M_DATA, HTRANS=00; for a write, drive HWDATA=wdata_reg.
  - M_DATA: wait for HREADY=1, then return to M_IDLE.
    - Read: rdata_reg<=HRDATA.
    - If HRESP=1: set err; rdata_reg unchanged.
    - HWDATA holds until the next write.
  - busy=1 in M_ADDR and M_DATA.
  - Latency: UPD_DR edge → HTRANS=10 on the next edge; minimum 3 edges to M_IDLE.
- Boundary cases:
  - Request while busy: the request is dropped and overrun is set. A request arriving on the same edge busy clears is still dropped.
  - TAP reaching TLR via TMS does not abort an in-flight transfer. Only TRST aborts, with HTRANS=00 on that edge.
  - RDATA capture while busy returns the stale rdata_reg.
  - err and overrun are both set and cleared via STATUS in the same edge: set wins.

Optional Feature:
- JTAG_AUTOINC_EN defined:
  - addr_reg += DATA_W/8 on each M_DATA completion with HRESP=0.
  - Wraps modulo 2^ADDR_W.
  - Enables streaming back-to-back WDATA/RDATA updates.
- Undefined: addr_reg changes only via ADDR update.

Decomposition:
- Package jtag_pkg holds:
  - TAP state typedef with the codes above;
  - opcode constants;
  - HTRANS_IDLE/HTRANS_NONSEQ constants;
  - AHB FSM state typedef (M_IDLE, M_ADDR, M_DATA).
- One sub-module, jtag_tap_fsm: TCK/TRST/TMS in, state out, plus one-hot decodes cap_dr/shift_dr/upd_dr/cap_ir/shift_ir/upd_ir.
- The top holds the IR, DR chains, AHB FSM and TDO mux.

Test Plan:
- TRST pulse, then IR=IDCODE, shift 32 bits of DR → TDO stream is F0F0F0F0 LSB-first (0,0,0,0,1,1,1,1,...); HTRANS=00 throughout.
- ADDR=0x2000_0010, WDATA=0xDEADBEEF, HREADY=1 → one NONSEQ write with HADDR=0x2000_0010 and HWRITE=1; next cycle HWDATA=0xDEADBEEF; STATUS reads 000.
- RDATA update with HRDATA=0x1234_5678 and HREADY low for 3 cycles in the data phase → busy=1 during the stall; a second RDATA capture shifts out 0x12345678.
- Write with HRESP=1 in the data phase → STATUS=010; STATUS update clears it, next capture reads 000.
- Second WDATA update while HREADY=0 holds the first transfer → only one NONSEQ issued; STATUS=100.
- With JTAG_AUTOINC_EN: ADDR=0xFFFF_FFFC, two writes → HADDR 0xFFFF_FFFC then 0x0000_0000. Without the macro, both writes go to 0xFFFF_FFFC.
